// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit_pkg
//  Description : Shared encodings for the forwarding / hazard unit
//                (ALU operand source selects, hard-wired zero register).
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_unit_pkg;

  // ALU operand source select encoding
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,   // register file read data
    FWD_MEM = 2'b01,   // EX/MEM result
    FWD_WB  = 2'b10    // MEM/WB result
  } fwd_sel_e;

  // Architectural register that always reads as zero
  localparam int REG_ZERO = 0;

endpackage : fwd_hazard_unit_pkg
`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit_if
//  Description : Pipeline-side bundle of the forwarding / hazard unit:
//                decode/execute/memory/write-back register fields in,
//                forwarding selects, stall controls and stall count out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Decode stage
  logic [REG_AW-1:0] D_Rs;
  logic [REG_AW-1:0] D_Rt;
  logic              D_UseRs;
  logic              D_UseRt;
  logic              D_MduUse;
  // Execute stage
  logic [REG_AW-1:0] E_Rs;
  logic [REG_AW-1:0] E_Rt;
  logic              E_ALUSrc;
  logic [REG_AW-1:0] E_Rw;
  logic              E_RegWr;
  logic              E_MemRd;
  logic              E_MduStart;
  // Memory stage
  logic [REG_AW-1:0] M_Rw;
  logic              M_RegWr;
  logic              M_MemRd;
  // Write-back stage
  logic [REG_AW-1:0] W_Rw;
  logic              W_RegWr;
  // Counter control
  logic              StallCntClr;
  // Results
  logic [1:0]        ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic              Stall;
  logic              Flush_E;
  logic              MduBusy;
  logic [CNT_W-1:0]  StallCnt;

  // Pipeline side: supplies register fields, consumes controls
  modport master (
    output D_Rs, D_Rt, D_UseRs, D_UseRt, D_MduUse,
    output E_Rs, E_Rt, E_ALUSrc, E_Rw, E_RegWr, E_MemRd, E_MduStart,
    output M_Rw, M_RegWr, M_MemRd, W_Rw, W_RegWr, StallCntClr,
    input  ALUSrcA, ALUSrcB, Stall, Flush_E, MduBusy, StallCnt
  );

  // Hazard unit side
  modport slave (
    input  D_Rs, D_Rt, D_UseRs, D_UseRt, D_MduUse,
    input  E_Rs, E_Rt, E_ALUSrc, E_Rw, E_RegWr, E_MemRd, E_MduStart,
    input  M_Rw, M_RegWr, M_MemRd, W_Rw, W_RegWr, StallCntClr,
    output ALUSrcA, ALUSrcB, Stall, Flush_E, MduBusy, StallCnt
  );

endinterface : fwd_hazard_unit_if
`default_nettype wire

// File: rtl/fwd_hazard_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit_fwd_sel
//  Description : Forwarding select for one ALU operand. MEM beats WB; a
//                load in MEM cannot forward (data not yet available), and
//                register zero is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit_fwd_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  wire logic [REG_AW-1:0] src,
  input  wire logic              force_rf,
  input  wire logic [REG_AW-1:0] m_rw,
  input  wire logic              m_regwr,
  input  wire logic              m_memrd,
  input  wire logic [REG_AW-1:0] w_rw,
  input  wire logic              w_regwr,
  output logic [1:0]             sel
);

  localparam logic [REG_AW-1:0] c_zero = REG_AW'(REG_ZERO);

  generate
    if (FWD_EN) begin : g_fwd
      logic w_src_nz;
      logic w_mem_hit;
      logic w_wb_hit;

      assign w_src_nz  = (src != c_zero);
      assign w_mem_hit = m_regwr & (m_rw != c_zero) & w_src_nz & (m_rw == src) & ~m_memrd;
      assign w_wb_hit  = w_regwr & (w_rw != c_zero) & w_src_nz & (w_rw == src);

      // Priority select: immediate operand overrides, then MEM, then WB
      always_comb begin
        sel = FWD_RF;
        if (force_rf)       sel = FWD_RF;
        else if (w_mem_hit) sel = FWD_MEM;
        else if (w_wb_hit)  sel = FWD_WB;
      end
    end else begin : g_nofwd
      logic w_unused;
      assign w_unused = &{1'b0, src, force_rf, m_rw, m_regwr, m_memrd, w_rw, w_regwr};
      assign sel      = FWD_RF;
    end
  endgenerate

endmodule : fwd_hazard_unit_fwd_sel
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Execute-stage operand forwarding plus decode-stage hazard
//                detection (load-use, no-forwarding RAW, MDU busy). Drives
//                stall/bubble and keeps a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter bit FWD_EN  = 1'b1,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input wire logic          clk,
  input wire logic          rst_n,
  fwd_hazard_unit_if.slave  bus
);

  localparam int                MDU_W     = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;
  localparam logic [MDU_W-1:0]  c_mdu_lat = MDU_W'(MDU_LAT);
  localparam logic [REG_AW-1:0] c_zero    = REG_AW'(REG_ZERO);

  logic [MDU_W-1:0] r_mdu_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_rd_a;
  logic w_rd_b;
  logic w_hit_e;
  logic w_hit_m;
  logic w_load_use;
  logic w_nofwd_haz;
  logic w_mdu_haz;
  logic w_mdu_busy;
  logic w_stall;

  // --------------------------------------------------------------------------
  // Operand forwarding
  // --------------------------------------------------------------------------
  fwd_hazard_unit_fwd_sel #(
    .REG_AW (REG_AW),
    .FWD_EN (FWD_EN)
  ) u_fwd_sel_a (
    .src      (bus.E_Rs),
    .force_rf (1'b0),
    .m_rw     (bus.M_Rw),
    .m_regwr  (bus.M_RegWr),
    .m_memrd  (bus.M_MemRd),
    .w_rw     (bus.W_Rw),
    .w_regwr  (bus.W_RegWr),
    .sel      (bus.ALUSrcA)
  );

  fwd_hazard_unit_fwd_sel #(
    .REG_AW (REG_AW),
    .FWD_EN (FWD_EN)
  ) u_fwd_sel_b (
    .src      (bus.E_Rt),
    .force_rf (bus.E_ALUSrc),
    .m_rw     (bus.M_Rw),
    .m_regwr  (bus.M_RegWr),
    .m_memrd  (bus.M_MemRd),
    .w_rw     (bus.W_Rw),
    .w_regwr  (bus.W_RegWr),
    .sel      (bus.ALUSrcB)
  );

  // --------------------------------------------------------------------------
  // Decode-stage hazards. WB never needs a stall because the register file
  // writes in the first half-cycle and reads in the second.
  // --------------------------------------------------------------------------
  assign w_rd_a = bus.D_UseRs & (bus.D_Rs != c_zero);
  assign w_rd_b = bus.D_UseRt & (bus.D_Rt != c_zero);

  // Producer in EX / MEM writes a register that decode is about to read
  always_comb begin
    w_hit_e = bus.E_RegWr & (bus.E_Rw != c_zero) &
              ((w_rd_a & (bus.E_Rw == bus.D_Rs)) | (w_rd_b & (bus.E_Rw == bus.D_Rt)));
    w_hit_m = bus.M_RegWr & (bus.M_Rw != c_zero) &
              ((w_rd_a & (bus.M_Rw == bus.D_Rs)) | (w_rd_b & (bus.M_Rw == bus.D_Rt)));
  end

  assign w_mdu_busy  = (r_mdu_cnt != '0);
  assign w_load_use  = bus.E_MemRd & w_hit_e;
  assign w_nofwd_haz = ~FWD_EN & (w_hit_e | w_hit_m);
  assign w_mdu_haz   = bus.D_MduUse & w_mdu_busy;
  assign w_stall     = w_load_use | w_nofwd_haz | w_mdu_haz;

  assign bus.Stall    = w_stall;
  assign bus.Flush_E  = w_stall;
  assign bus.MduBusy  = w_mdu_busy;
  assign bus.StallCnt = r_stall_cnt;

  // MDU result countdown; a new start (even while busy) reloads the full latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdu_cnt <= '0;
    end else if (bus.E_MduStart && (MDU_LAT > 0)) begin
      r_mdu_cnt <= c_mdu_lat;
    end else if (r_mdu_cnt != '0) begin
      r_mdu_cnt <= r_mdu_cnt - MDU_W'(1);
    end
  end

  // Stall-cycle counter: clear wins, otherwise count stalled cycles and hold at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (bus.StallCntClr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule : fwd_hazard_unit
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Scoreboard bench for fwd_hazard_unit. Two instances share
//                the same stimulus: one with forwarding (32-bit counter) and
//                one without forwarding (3-bit counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int MDU_LAT = 4;

  typedef struct {
    bit       rst_n;
    bit [4:0] d_rs, d_rt, e_rs, e_rt, e_rw, m_rw, w_rw;
    bit       d_users, d_usert, d_mduuse;
    bit       e_alusrc, e_regwr, e_memrd, e_mdustart;
    bit       m_regwr, m_memrd, w_regwr, clr;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [1:0]  a0, b0, a1, b1;
    logic        s0, s1, mb;
    logic [31:0] c0;
    logic [2:0]  c1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  fwd_hazard_unit_if #(.REG_AW(5), .CNT_W(32)) bus_f ();
  fwd_hazard_unit_if #(.REG_AW(5), .CNT_W(3))  bus_n ();

  fwd_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .MDU_LAT(MDU_LAT), .CNT_W(32)) dut_f (
    .clk (clk), .rst_n (rst_n), .bus (bus_f)
  );
  fwd_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .MDU_LAT(MDU_LAT), .CNT_W(3)) dut_n (
    .clk (clk), .rst_n (rst_n), .bus (bus_n)
  );

  always #5 clk = ~clk;

  stim_t  s;
  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     last_start = -100;
  longint tot0 = 0;
  longint tot1 = 0;

  // ---------------------------------------------------------------- model
  // Operand source chosen from the architectural rules
  function automatic logic [1:0] m_fwd(bit fen, bit [4:0] src, bit imm);
    if (!fen || imm || src == 5'd0) return 2'b00;
    if (s.m_regwr && !s.m_memrd && s.m_rw == src) return 2'b01;
    if (s.w_regwr && s.w_rw == src) return 2'b10;
    return 2'b00;
  endfunction

  // Does a producer writing rw feed a register decode reads?
  function automatic bit m_feeds(bit regwr, bit [4:0] rw);
    if (!regwr || rw == 5'd0) return 1'b0;
    return (s.d_users && s.d_rs == rw) || (s.d_usert && s.d_rt == rw);
  endfunction

  task automatic drive();
    rst_n = s.rst_n;
    bus_f.D_Rs = s.d_rs;   bus_n.D_Rs = s.d_rs;
    bus_f.D_Rt = s.d_rt;   bus_n.D_Rt = s.d_rt;
    bus_f.D_UseRs = s.d_users;   bus_n.D_UseRs = s.d_users;
    bus_f.D_UseRt = s.d_usert;   bus_n.D_UseRt = s.d_usert;
    bus_f.D_MduUse = s.d_mduuse; bus_n.D_MduUse = s.d_mduuse;
    bus_f.E_Rs = s.e_rs;   bus_n.E_Rs = s.e_rs;
    bus_f.E_Rt = s.e_rt;   bus_n.E_Rt = s.e_rt;
    bus_f.E_ALUSrc = s.e_alusrc; bus_n.E_ALUSrc = s.e_alusrc;
    bus_f.E_Rw = s.e_rw;   bus_n.E_Rw = s.e_rw;
    bus_f.E_RegWr = s.e_regwr;   bus_n.E_RegWr = s.e_regwr;
    bus_f.E_MemRd = s.e_memrd;   bus_n.E_MemRd = s.e_memrd;
    bus_f.E_MduStart = s.e_mdustart; bus_n.E_MduStart = s.e_mdustart;
    bus_f.M_Rw = s.m_rw;   bus_n.M_Rw = s.m_rw;
    bus_f.M_RegWr = s.m_regwr;   bus_n.M_RegWr = s.m_regwr;
    bus_f.M_MemRd = s.m_memrd;   bus_n.M_MemRd = s.m_memrd;
    bus_f.W_Rw = s.w_rw;   bus_n.W_Rw = s.w_rw;
    bus_f.W_RegWr = s.w_regwr;   bus_n.W_RegWr = s.w_regwr;
    bus_f.StallCntClr = s.clr;   bus_n.StallCntClr = s.clr;
  endtask

  task automatic idle();
    s = '{default: 0};
    s.rst_n = 1'b1;
  endtask

  // One pipeline cycle: apply inputs, queue the expected response, advance model
  task automatic step();
    exp_t e;
    bit   busy, he, hm, st0, st1;
    @(posedge clk);
    #1;
    drive();
    if (!s.rst_n) begin
      last_start = -100;
      tot0 = 0;
      tot1 = 0;
    end
    busy = (cyc - last_start >= 1) && (cyc - last_start <= MDU_LAT);
    he   = m_feeds(s.e_regwr, s.e_rw);
    hm   = m_feeds(s.m_regwr, s.m_rw);
    st0  = (s.e_memrd && he) || (s.d_mduuse && busy);
    st1  = st0 || he || hm;
    e.cyc = cyc;
    e.a0  = m_fwd(1'b1, s.e_rs, 1'b0);
    e.b0  = m_fwd(1'b1, s.e_rt, s.e_alusrc);
    e.a1  = m_fwd(1'b0, s.e_rs, 1'b0);
    e.b1  = m_fwd(1'b0, s.e_rt, s.e_alusrc);
    e.s0  = st0;
    e.s1  = st1;
    e.mb  = busy;
    e.c0  = (tot0 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(tot0);
    e.c1  = (tot1 > 7) ? 3'd7 : 3'(tot1);
    q.push_back(e);
    if (s.rst_n) begin
      if (s.clr) begin
        tot0 = 0;
        tot1 = 0;
      end else begin
        tot0 += longint'(st0);
        tot1 += longint'(st1);
      end
      if (s.e_mdustart) last_start = cyc;
    end
    cyc++;
  endtask

  // ---------------------------------------------------------------- checker
  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, act, req);
    end
  endtask

  // Monitor: compare whatever the DUTs present against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwd_ALUSrcA",    e.cyc, 32'(bus_f.ALUSrcA),  32'(e.a0));
      chk("fwd_ALUSrcB",    e.cyc, 32'(bus_f.ALUSrcB),  32'(e.b0));
      chk("fwd_Stall",      e.cyc, 32'(bus_f.Stall),    32'(e.s0));
      chk("fwd_Flush_E",    e.cyc, 32'(bus_f.Flush_E),  32'(e.s0));
      chk("fwd_MduBusy",    e.cyc, 32'(bus_f.MduBusy),  32'(e.mb));
      chk("fwd_StallCnt",   e.cyc, bus_f.StallCnt,      e.c0);
      chk("nofwd_ALUSrcA",  e.cyc, 32'(bus_n.ALUSrcA),  32'(e.a1));
      chk("nofwd_ALUSrcB",  e.cyc, 32'(bus_n.ALUSrcB),  32'(e.b1));
      chk("nofwd_Stall",    e.cyc, 32'(bus_n.Stall),    32'(e.s1));
      chk("nofwd_Flush_E",  e.cyc, 32'(bus_n.Flush_E),  32'(e.s1));
      chk("nofwd_MduBusy",  e.cyc, 32'(bus_n.MduBusy),  32'(e.mb));
      chk("nofwd_StallCnt", e.cyc, 32'(bus_n.StallCnt), 32'(e.c1));
    end
  end

  // Watchdog against a stuck run
  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    idle();
    s.rst_n = 1'b0;
    drive();
    step();
    step();
    idle(); step();

    // MEM/WB forwarding priority and immediate operand
    idle();
    s.e_rs = 5; s.e_rt = 5; s.m_rw = 5; s.m_regwr = 1; s.w_rw = 5; s.w_regwr = 1;
    step();
    s.m_regwr = 0; step();
    s.e_alusrc = 1; step();

    // Register zero never forwards or stalls
    idle();
    s.m_regwr = 1; s.w_regwr = 1; s.e_regwr = 1; s.d_users = 1; s.d_usert = 1;
    step();

    // Load-use, then the load sitting in MEM with WB also writing r8
    idle();
    s.e_memrd = 1; s.e_rw = 8; s.e_regwr = 1; s.d_rt = 8; s.d_usert = 1;
    step();
    idle();
    s.e_rt = 8; s.m_memrd = 1; s.m_rw = 8; s.m_regwr = 1; s.w_rw = 8; s.w_regwr = 1;
    step();

    // No-forwarding RAW from MEM stalls; WB-only producer does not
    idle();
    s.m_rw = 3; s.m_regwr = 1; s.d_rs = 3; s.d_users = 1;
    step();
    idle();
    s.w_rw = 3; s.w_regwr = 1; s.d_rs = 3; s.d_users = 1;
    step();

    // MDU busy window with a dependent decode held waiting
    idle(); s.clr = 1; step();
    idle(); s.e_mdustart = 1; step();
    idle(); s.d_mduuse = 1;
    for (int i = 0; i < MDU_LAT + 1; i++) step();

    // Restart while busy at count 2
    idle(); s.e_mdustart = 1; step();
    idle(); step(); step();
    s.e_mdustart = 1; step();
    idle();
    for (int i = 0; i < MDU_LAT + 1; i++) step();

    // Asynchronous reset in the middle of an MDU op
    idle(); s.e_mdustart = 1; step();
    idle(); s.d_mduuse = 1; step();
    s.rst_n = 1'b0; step();
    idle(); s.d_mduuse = 1; step();

    // Saturation of the narrow counter, then clear
    idle(); s.clr = 1; step();
    idle();
    s.e_memrd = 1; s.e_rw = 9; s.e_regwr = 1; s.d_rs = 9; s.d_users = 1;
    for (int i = 0; i < 9; i++) step();
    idle(); step();
    s.clr = 1; step();
    idle(); step();

    // Randomised traffic over a small register window to provoke many matches
    for (int i = 0; i < 400; i++) begin
      s.rst_n      = 1'b1;
      s.d_rs       = 5'($urandom_range(0, 3));
      s.d_rt       = 5'($urandom_range(0, 3));
      s.e_rs       = 5'($urandom_range(0, 3));
      s.e_rt       = 5'($urandom_range(0, 3));
      s.e_rw       = 5'($urandom_range(0, 3));
      s.m_rw       = 5'($urandom_range(0, 3));
      s.w_rw       = 5'($urandom_range(0, 3));
      s.d_users    = 1'($urandom);
      s.d_usert    = 1'($urandom);
      s.d_mduuse   = 1'($urandom);
      s.e_alusrc   = ($urandom_range(0, 3) == 0);
      s.e_regwr    = 1'($urandom);
      s.e_memrd    = 1'($urandom);
      s.e_mdustart = ($urandom_range(0, 7) == 0);
      s.m_regwr    = 1'($urandom);
      s.m_memrd    = 1'($urandom);
      s.w_regwr    = 1'($urandom);
      s.clr        = ($urandom_range(0, 29) == 0);
      step();
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fwd_hazard_unit
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the execute-stage forwarding control for the 5-stage MIPS pipeline.
- Generates ALU operand forwarding selects from MEM/WB, and detects load-use and multiply/divide (MDU) hazards at decode.
- Drives pipeline stall/bubble signals and keeps a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline registers, between hazard sources (EX/MEM/WB) and the PC/IF-ID enables.

Parameters:
- REG_AW, 5, register index width (2**REG_AW architectural registers; index 0 is hard-wired zero).
- FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, every RAW hazard resolved by stall.
- MDU_LAT, 4, cycles the MDU result is unavailable after issue (0 = single-cycle MDU, never busy).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset
- D_Rs  in  REG_AW  decode-stage source Rs
- D_Rt  in  REG_AW  decode-stage source Rt
- D_UseRs  in  1  decode instruction reads Rs
- D_UseRt  in  1  decode instruction reads Rt
- D_MduUse  in  1  decode instruction reads MDU result or issues an MDU op
- E_Rs  in  REG_AW  execute-stage Rs
- E_Rt  in  REG_AW  execute-stage Rt
- E_ALUSrc  in  1  operand B is immediate
- E_Rw  in  REG_AW  execute-stage destination
- E_RegWr  in  1  execute-stage register write enable
- E_MemRd  in  1  execute-stage instruction is a load
- E_MduStart  in  1  valid MDU op in EX this cycle
- M_Rw  in  REG_AW  memory-stage destination
- M_RegWr  in  1  memory-stage write enable
- M_MemRd  in  1  memory-stage instruction is a load
- W_Rw  in  REG_AW  write-back destination
- W_RegWr  in  1  write-back write enable
- StallCntClr  in  1  synchronous clear of StallCnt
- ALUSrcA  out  2  operand A select: 00 register file, 01 MEM result, 10 WB result
- ALUSrcB  out  2  operand B select, same encoding
- Stall  out  1  hold PC and IF/ID
- Flush_E  out  1  load a bubble into ID/EX
- MduBusy  out  1  MDU result pending
- StallCnt  out  CNT_W  number of stalled cycles

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: mdu_cnt=0, MduBusy=0, StallCnt=0. ALUSrcA, ALUSrcB, Stall and Flush_E are combinational and are therefore 00/00/0/0 while in reset with mdu_cnt=0.

Forwarding (combinational, FWD_EN=1):
- Match conditions:
  - C1x = M_RegWr & M_Rw≠0 & src≠0 & M_Rw==src & !M_MemRd
  - C2x = W_RegWr & W_Rw≠0 & src≠0 & W_Rw==src
- Priority: MEM beats WB.
- ALUSrcB is forced to 00 when E_ALUSrc=1.
- FWD_EN=0: both selects are constant 00.

Hazards (combinational):
- rdA = D_UseRs & D_Rs≠0; rdB = D_UseRt & D_Rt≠0.
- hit(X) is true when X_RegWr, X_Rw≠0, and X_Rw equals D_Rs (with rdA) or D_Rt (with rdB).
- LoadUse = E_MemRd & hit(E).
- NoFwdHaz = !FWD_EN & (hit(E) | hit(M)). The register file writes before it reads, so WB needs no stall.
- MduHaz = D_MduUse & MduBusy.
- Stall = Flush_E = LoadUse | NoFwdHaz | MduHaz.

MDU counter (sequential):
- E_MduStart and MDU_LAT>0: mdu_cnt <= MDU_LAT. This takes precedence over the decrement, and a start while busy restarts the count.
- Otherwise, if mdu_cnt≠0: mdu_cnt decrements by 1.
- MduBusy = (mdu_cnt≠0). It is high for exactly MDU_LAT cycles, starting the cycle after E_MduStart.
- Counter width: $clog2(MDU_LAT+1), minimum 1.
- A bubble in EX must present E_MduStart=0.

StallCnt:
- StallCntClr has priority: StallCnt <= 0.
- Otherwise, when Stall=1, StallCnt increments and saturates at all-ones, never wrapping.

Other rules:
- rst_n asserted mid-MDU-op clears mdu_cnt immediately, so MduBusy drops asynchronously.
- Simultaneous LoadUse and MduHaz produce a single stall; StallCnt counts cycles, not causes.

Decomposition:
- Shared package: the ALUSrc encodings (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and the REG_ZERO constant.
- One natural sub-module, fwd_sel: the per-operand match/priority logic, instantiated twice.
- Hazard logic and counters live in the top module.

Test Plan:
- MEM/WB forwarding: E_Rs=E_Rt=5, M_Rw=5/M_RegWr=1, W_Rw=5/W_RegWr=1, E_ALUSrc=0 -> ALUSrcA=ALUSrcB=01. Drop M_RegWr -> 10. Set E_ALUSrc=1 -> ALUSrcB=00.
- Register zero: all Rw and Rs set to 0 with writes enabled -> ALUSrcA/B=00 and Stall=0.
- Load-use: E_MemRd=1, E_Rw=8, E_RegWr=1, D_Rt=8, D_UseRt=1 -> Stall=Flush_E=1 for one cycle. Next cycle: M_MemRd=1 and W_Rw=8 path gives ALUSrcB=10, and MEM is not selected.
- MDU, MDU_LAT=4: E_MduStart pulse -> MduBusy high for 4 cycles. D_MduUse held high -> Stall for 4 cycles, StallCnt=4. Restart at count 2 -> busy for 4 more cycles.
- FWD_EN=0: M_Rw=3/M_RegWr=1 with D_Rs=3/D_UseRs=1 -> Stall=1 and ALUSrcA=00. W_Rw=3 only -> Stall=0.
- Reset and saturation: assert rst_n=0 mid-MDU count -> MduBusy=0 and StallCnt=0 immediately. With CNT_W=3, 9 stalled cycles -> StallCnt=7. StallCntClr -> 0.
